// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined add/subtract with carry/borrow, two's-complement overflow and optional saturation.
// Elastic valid/ready pipeline: every stage loads from its predecessor together whenever the output slot is free.
module addsub_pipe #(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned STAGES    = 2,
  parameter int unsigned SIGNED    = 0,
  parameter int unsigned SATURATE  = 0
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic                 op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] result,
  output logic                 cb,
  output logic                 ovf
);

  localparam int unsigned MSB = DATAWIDTH - 1;

  typedef struct packed {
    logic [DATAWIDTH-1:0] res;
    logic                 cb;
    logic                 ovf;
  } stage_t;

  logic [DATAWIDTH:0]   wide_c;
  logic [DATAWIDTH-1:0] sum_c;
  logic [DATAWIDTH-1:0] res_c;
  logic                 cb_c;
  logic                 ovf_c;
  logic                 advance;

  stage_t               stage_q [STAGES];
  logic [STAGES-1:0]    vld_q;

  // Stage-1 arithmetic: zero-extended add/sub, flags, then optional clamping.
  always_comb begin
    wide_c = op ? ({1'b0, a} + {1'b0, b}) : ({1'b0, a} - {1'b0, b});
    sum_c  = wide_c[MSB:0];
    cb_c   = wide_c[DATAWIDTH];
    if (op) begin
      ovf_c = (a[MSB] == b[MSB]) && (sum_c[MSB] != a[MSB]);
    end else begin
      ovf_c = (a[MSB] != b[MSB]) && (sum_c[MSB] != a[MSB]);
    end
    res_c = sum_c;
    if (SATURATE != 0) begin
      if (SIGNED == 0) begin
        if (cb_c) begin
          res_c = op ? {DATAWIDTH{1'b1}} : {DATAWIDTH{1'b0}};
        end
      end else if (ovf_c) begin
        // On overflow the true value carries the sign of a.
        res_c = a[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
      end
    end
  end

  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;

  // Whole pipeline shifts as one when the last stage is free or being drained.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      vld_q <= '0;
      for (int i = 0; i < int'(STAGES); i++) begin
        stage_q[i] <= '0;
      end
    end else if (advance) begin
      vld_q[0]   <= in_valid;
      stage_q[0] <= {res_c, cb_c, ovf_c};
      for (int i = 1; i < int'(STAGES); i++) begin
        vld_q[i]   <= vld_q[i-1];
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign result    = stage_q[STAGES-1].res;
  assign cb        = stage_q[STAGES-1].cb;
  assign ovf       = stage_q[STAGES-1].ovf;

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: five configurations share one stimulus stream; a driver pushes expected
// results into per-instance queues on acceptance and a monitor pops and compares on delivery.
module tb_addsub_pipe;

  localparam int NI = 5;
  localparam int ST_C  [NI] = '{2, 2, 2, 1, 4};
  localparam int SAT_C [NI] = '{0, 1, 1, 0, 0};
  localparam int SGN_C [NI] = '{0, 0, 1, 0, 0};

  typedef struct {
    logic [7:0] res;
    logic       cb;
    logic       ovf;
    int         acc;
  } exp_t;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic       op;
  logic       out_ready;

  logic [NI-1:0] in_ready_v;
  logic [NI-1:0] out_valid_v;
  logic [NI-1:0] cb_v;
  logic [NI-1:0] ovf_v;
  logic [7:0]    result_v [NI];

  exp_t q [NI][$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  bit   done  = 1'b0;

  always #5 Clk = ~Clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    addsub_pipe #(
      .DATAWIDTH(8),
      .STAGES   (ST_C[g]),
      .SIGNED   (SGN_C[g]),
      .SATURATE (SAT_C[g])
    ) u_dut (
      .Clk      (Clk),
      .Rst      (Rst),
      .in_valid (in_valid),
      .in_ready (in_ready_v[g]),
      .a        (a),
      .b        (b),
      .op       (op),
      .out_valid(out_valid_v[g]),
      .out_ready(out_ready),
      .result   (result_v[g]),
      .cb       (cb_v[g]),
      .ovf      (ovf_v[g])
    );
  end

  // Reference: true integer value, then flags and clamping from their definitions.
  function automatic exp_t model(input logic [7:0] av, input logic [7:0] bv, input logic opv, input int i);
    exp_t e;
    int ua, ub, sa, sb, tu, ts;
    ua = int'(av);
    ub = int'(bv);
    sa = int'($signed(av));
    sb = int'($signed(bv));
    tu = opv ? ua + ub : ua - ub;
    ts = opv ? sa + sb : sa - sb;
    e.cb  = opv ? (tu > 255) : (ua < ub);
    e.ovf = (ts > 127) || (ts < -128);
    e.res = 8'(tu);
    if (SAT_C[i] != 0) begin
      if (SGN_C[i] == 0) begin
        if (e.cb) e.res = opv ? 8'hFF : 8'h00;
      end else if (e.ovf) begin
        e.res = (ts > 0) ? 8'h7F : 8'h80;
      end
    end
    e.acc = 0;
    return e;
  endfunction

  task automatic chk(input string name, input int inst, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s[%0d] cyc=%0d got=%0h want=%0h", name, inst, cyc, act, req);
    end
  endtask

  task automatic step(input logic r, input logic iv, input logic [7:0] av, input logic [7:0] bv,
                      input logic opv, input logic ordy);
    exp_t e;
    @(negedge Clk);
    cyc++;
    Rst = r; in_valid = iv; a = av; b = bv; op = opv; out_ready = ordy;
    #1;
    if (!Rst && in_valid) begin
      for (int i = 0; i < NI; i++) begin
        if (in_ready_v[i]) begin
          e = model(av, bv, opv, i);
          e.acc = cyc;
          q[i].push_back(e);
        end
      end
    end
  endtask

  task automatic rand_step(input int vpct, input int rpct);
    step(1'b0, 1'($urandom_range(0, 99) < vpct), 8'($urandom), 8'($urandom),
         1'($urandom), 1'($urandom_range(0, 99) < rpct));
  endtask

  // Driver
  initial begin : driver
    Rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);

    // Directed corner vectors (wrap, unsigned clamp, signed clamp)
    step(1'b0, 1'b1, 8'h05, 8'h07, 1'b0, 1'b1);
    step(1'b0, 1'b1, 8'hF0, 8'h20, 1'b1, 1'b1);
    step(1'b0, 1'b1, 8'h70, 8'h20, 1'b1, 1'b1);
    step(1'b0, 1'b1, 8'h80, 8'h01, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);

    // Six-pair stream with the consumer stalled for cycles 3-5
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'(k < 6), 8'($urandom), 8'($urandom), 1'($urandom), 1'(!(k >= 3 && k <= 5)));
    end

    for (int k = 0; k < 300; k++) rand_step(75, 70);

    // Reset with two operations in flight
    for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    step(1'b0, 1'b1, 8'h7F, 8'h01, 1'b1, 1'b1);
    step(1'b0, 1'b1, 8'h10, 8'h20, 1'b0, 1'b1);
    @(posedge Clk);
    #2;
    Rst = 1'b1;
    in_valid = 1'b0;
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);

    for (int k = 0; k < 150; k++) rand_step(60, 50);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    done = 1'b1;
  end

  // Monitor
  initial begin : monitor
    exp_t e;
    int last_stall [NI];
    for (int i = 0; i < NI; i++) last_stall[i] = -1;
    forever begin
      @(negedge Clk);
      #2;
      if (done) break;
      for (int i = 0; i < NI; i++) begin
        if (Rst) begin
          chk("rst_out_valid", i, out_valid_v[i], 0);
          chk("rst_result", i, result_v[i], 0);
          chk("rst_cb", i, cb_v[i], 0);
          chk("rst_ovf", i, ovf_v[i], 0);
          chk("rst_in_ready", i, in_ready_v[i], 1);
          q[i].delete();
        end else begin
          chk("in_ready", i, in_ready_v[i], longint'(out_ready || !out_valid_v[i]));
          if (!out_ready) last_stall[i] = cyc;
          if (out_valid_v[i]) begin
            if (q[i].size() == 0) begin
              chk("spurious_valid", i, out_valid_v[i], 0);
            end else begin
              e = q[i][0];
              chk("result", i, result_v[i], e.res);
              chk("cb", i, cb_v[i], e.cb);
              chk("ovf", i, ovf_v[i], e.ovf);
              if (out_ready) begin
                if (last_stall[i] < e.acc) chk("latency", i, cyc - e.acc, ST_C[i]);
                void'(q[i].pop_front());
              end
            end
          end
        end
      end
    end
    for (int i = 0; i < NI; i++) chk("leftover", i, q[i].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/addsub_pipe.md
ADDSUB_PIPE -- requirements
Module: addsub_pipe

Interface
- REQ-001 The block SHALL have parameter DATAWIDTH, default 8, giving the operand and result width in bits (legal range 2..64).
- REQ-002 The block SHALL have parameter STAGES, default 2, giving the pipeline depth in register stages (legal range 1..4).
- REQ-003 The block SHALL have parameter SIGNED, default 0, where 0 selects unsigned saturation and 1 selects two's-complement saturation.
- REQ-004 The block SHALL have parameter SATURATE, default 0, where 0 selects wrap-around results and 1 selects clamped results.
- REQ-005 The block SHALL have port Clk, input, 1 bit, the single clock, rising-edge active.
- REQ-006 The block SHALL have port Rst, input, 1 bit, the reset, asynchronous and active-high.
- REQ-007 The block SHALL have port in_valid, input, 1 bit, indicating an operand pair is offered.
- REQ-008 The block SHALL have port in_ready, output, 1 bit, indicating the block accepts the offered pair this cycle.
- REQ-009 The block SHALL have ports a and b, input, DATAWIDTH bits each, the operands.
- REQ-010 The block SHALL have port op, input, 1 bit, where 0 computes a-b and 1 computes a+b.
- REQ-011 The block SHALL have port out_valid, output, 1 bit, indicating result and flags are valid.
- REQ-012 The block SHALL have port out_ready, input, 1 bit, indicating the consumer takes the result this cycle.
- REQ-013 The block SHALL have port result, output, DATAWIDTH bits, the registered result.
- REQ-014 The block SHALL have port cb, output, 1 bit, the unsigned carry (add) or borrow (sub).
- REQ-015 The block SHALL have port ovf, output, 1 bit, the two's-complement overflow.

Function
- REQ-016 The block SHALL accept a transfer on a rising edge when in_valid=1 and in_ready=1, and SHALL deliver a transfer when out_valid=1 and out_ready=1.
- REQ-017 The block SHALL define advance = out_ready OR NOT out_valid, and every pipeline stage (data and valid bit) SHALL load from its predecessor only when advance=1, holding otherwise.
- REQ-018 The block SHALL drive in_ready = advance combinationally, with no dependency on in_valid.
- REQ-019 A stage loaded from an input with in_valid=0 SHALL carry valid=0 (a bubble), and bubbles SHALL never assert out_valid.
- REQ-020 With advance held at 1, a result SHALL appear on out_valid exactly STAGES cycles after acceptance, with throughput one result per cycle.
- REQ-021 Stage 1 SHALL compute a (DATAWIDTH+1)-bit zero-extended sum or difference, and cb SHALL be bit DATAWIDTH of that value (for subtraction, cb=1 iff a<b unsigned).
- REQ-022 ovf SHALL be 1 when, for add, the operand signs are equal and the result sign differs, and for sub, the operand signs differ and the result sign differs from a.
- REQ-023 cb and ovf SHALL be reported for every result regardless of SIGNED and SATURATE.
- REQ-024 With SATURATE=0, result SHALL equal the low DATAWIDTH bits of the true value.
- REQ-025 With SATURATE=1 and SIGNED=0, result SHALL clamp to all-ones on add with cb=1 and to zero on sub with cb=1.
- REQ-026 With SATURATE=1 and SIGNED=1, result SHALL clamp on ovf=1 to the maximum positive value (0111..1) when the true value is positive and to the minimum value (1000..0) when it is negative.
- REQ-027 result, cb and ovf SHALL remain stable while out_valid=1 and out_ready=0.
- REQ-028 Results SHALL leave in acceptance order with no loss or duplication under any out_ready pattern.
- REQ-029 When acceptance and delivery occur in the same cycle with a full pipeline, both SHALL complete.

Reset
- REQ-030 Rst=1 SHALL immediately clear all stage valid bits, out_valid, result, cb and ovf to 0, independent of Clk.
- REQ-031 Reset mid-operation SHALL discard all in-flight operations, and no pre-reset result SHALL appear after release.
- REQ-032 in_ready SHALL be 1 while Rst=1 and following release, but no transfer SHALL be accepted during reset.

Verification (DATAWIDTH=8, STAGES=2 unless noted)
- REQ-033 The bench SHALL apply SATURATE=0, a=0x05, b=0x07, op=0, which SHALL produce result=0xFE, cb=1, ovf=0 two cycles after acceptance.
- REQ-034 The bench SHALL apply SATURATE=1, SIGNED=0, first with a=0x05, b=0x07, op=0, which SHALL produce result=0x00, cb=1, and then with a=0xF0, b=0x20, op=1, which SHALL produce result=0xFF, cb=1.
- REQ-035 The bench SHALL apply SATURATE=1, SIGNED=1, first with a=0x70, b=0x20, op=1, which SHALL produce result=0x7F, ovf=1, and then with a=0x80, b=0x01, op=0, which SHALL produce result=0x80, ovf=1.
- REQ-036 The bench SHALL stream 6 pairs with out_ready=0 for cycles 3-5, which SHALL hold out_valid=1 with a stable result, drive in_ready=0, and output all 6 results in order without duplicates.
- REQ-037 The bench SHALL assert Rst with 2 operations in flight, which SHALL drop out_valid to 0 in the same cycle, and after release with in_valid=0 for 5 cycles, out_valid SHALL stay 0.
- REQ-038 The bench SHALL set STAGES=1 and STAGES=4 and confirm latencies of 1 and 4 cycles respectively with out_ready=1.
